fetch_unit: RTL and testbench

- Multi-cycle instruction fetch stage for the processor. Owns the PC register and issues reads to a stalling instruction memory.
- Presents `instr`/`pc`/`pc_inc` to decode with a valid flag. Accepts the resolved `next_pc`/`redirect` from execute, a `stall` from downstream, and `halt` from decode.
- Replaces the single-cycle fetch when the memory system gains variable latency.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 19 +
 rtl/fetch_unit_pc_reg.sv | 31 +++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ    = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_HOLD   = 2'd2,
    FETCH_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [4:0]  OPC_HALT         = 5'b00000;
  localparam logic [4:0]  OPC_NOP          = 5'b00001;
  localparam logic [15:0] INSTR_NOP        = {OPC_NOP, 11'd0};
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Sequential PC step; 16-bit arithmetic wraps 0xFFFE to 0x0000 silently.
  function automatic logic [15:0] pc_plus2(input logic [15:0] pc_val);
    return pc_val + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
interface fetch_unit_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        imem_err;

  modport master (
    output imem_addr, imem_rd,
    input  imem_stall, imem_done, imem_data, imem_err
  );

  modport slave (
    input  imem_addr, imem_rd,
    output imem_stall, imem_done, imem_data, imem_err
  );
endinterface

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - 16-bit load-enabled register with reset value
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [15:0] d,
  output logic [15:0] q
);

  logic [15:0] val_q;
  logic [15:0] val_d;

  // Hold the current value unless a load is requested.
  always_comb begin
    val_d = val_q;
    if (ld) val_d = d;
  end

  // Register with synchronous reset to the configured value.
  always_ff @(posedge clk) begin
    if (rst) val_q <= RESET_VAL;
    else     val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multi-cycle instruction fetch against a stalling memory
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        err,
  input  logic [15:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        halt,
  fetch_unit_if.master imem,
  output logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] pc_inc,
  output logic        instr_valid
);

  fetch_state_e state_q, state_d;
  logic         err_q, err_d;
  logic         pc_ld, instr_ld;
  logic [15:0]  pc_d, pc_q, instr_q;
  logic         rd_o, valid_o;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .ld  (pc_ld),
    .d   (pc_d),
    .q   (pc_q)
  );

  pc_reg #(.RESET_VAL(NOP_INSTR)) u_instr_reg (
    .clk (clk),
    .rst (rst),
    .ld  (instr_ld),
    .d   (imem.imem_data),
    .q   (instr_q)
  );

  // State and sticky fault registers; reset abandons any in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next state, fault capture, instruction capture and next-PC selection.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    pc_ld    = 1'b0;
    pc_d     = pc_plus2(pc_q);
    instr_ld = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        // A misaligned PC is never sent to memory.
        if (pc_q[0]) begin
          err_d   = 1'b1;
          state_d = FETCH_HALTED;
        end else if (!imem.imem_stall) begin
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        // A fault wins over data arriving in the same cycle.
        if (imem.imem_err) begin
          err_d   = 1'b1;
          state_d = FETCH_HALTED;
        end else if (imem.imem_done) begin
          instr_ld = 1'b1;
          state_d  = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        // redirect/halt matter only in the cycle decode actually consumes.
        if (!stall) begin
          if (halt) begin
            state_d = FETCH_HALTED;
          end else begin
            pc_ld   = 1'b1;
            pc_d    = redirect ? next_pc : pc_plus2(pc_q);
            state_d = FETCH_REQ;
          end
        end
      end
      FETCH_HALTED: state_d = FETCH_HALTED;
      default:      state_d = FETCH_REQ;
    endcase
  end

  // Moore outputs, all forced quiet while reset is asserted.
  always_comb begin
    rd_o    = 1'b0;
    valid_o = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH_REQ:  rd_o    = ~pc_q[0];
        FETCH_HOLD: valid_o = 1'b1;
        default: begin
          rd_o    = 1'b0;
          valid_o = 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_rd   = rd_o;
  assign instr_valid    = valid_o;
  assign instr          = valid_o ? instr_q : NOP_INSTR;
  assign pc             = pc_q;
  assign pc_inc         = pc_plus2(pc_q);
  assign err            = err_q & ~rst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err;
  logic [15:0] next_pc = 16'h0000;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] instr, pc, pc_inc;
  logic        instr_valid;

  int n_checks = 0;
  int n_errs   = 0;

  logic [0:6] t_stall = 7'b1100000;
  logic [0:6] t_done  = 7'b0000010;
  logic [0:6] t_rd    = 7'b1110000;
  logic [0:6] t_valid = 7'b0000001;

  logic rd_seen, valid_seen;

  fetch_unit_if imem_bus();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .err         (err),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .stall       (stall),
    .halt        (halt),
    .imem        (imem_bus),
    .instr       (instr),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    imem_bus.imem_stall = 1'b0;
    imem_bus.imem_done  = 1'b0;
    imem_bus.imem_data  = 16'h0000;
    imem_bus.imem_err   = 1'b0;
  endtask

  // Leaves the bench in cycle 1 after reset release (REQ, inputs settled).
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    clear_mem();
    cyc(); #1;
    check("rst_rd",    32'(imem_bus.imem_rd), 32'd0);
    check("rst_valid", 32'(instr_valid),      32'd0);
    check("rst_err",   32'(err),              32'd0);
    check("rst_instr", 32'(instr),            32'h0800);
    check("rst_pc",    32'(pc),               32'h0000);
    cyc();
    rst = 1'b0;
    #1;
  endtask

  // From a settled REQ cycle: one accepted request, done in first WAIT cycle.
  task automatic fetch_to_hold(input logic [15:0] data);
    imem_bus.imem_stall = 1'b0;
    cyc();
    imem_bus.imem_done = 1'b1;
    imem_bus.imem_data = data;
    cyc();
    imem_bus.imem_done = 1'b0;
    #1;
  endtask

  task automatic consume(input logic redir, input logic [15:0] npc, input logic hlt);
    stall = 1'b0; redirect = redir; next_pc = npc; halt = hlt;
    cyc();
    redirect = 1'b0; halt = 1'b0;
    #1;
  endtask

  initial begin
    clear_mem();

    // Basic 3-cycle fetch
    do_reset();
    check("t1_c1_rd",    32'(imem_bus.imem_rd),   32'd1);
    check("t1_c1_addr",  32'(imem_bus.imem_addr), 32'h0000);
    check("t1_c1_instr", 32'(instr),              32'h0800);
    cyc();
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'h4123;
    #1;
    check("t1_c2_rd",    32'(imem_bus.imem_rd), 32'd0);
    check("t1_c2_valid", 32'(instr_valid),      32'd0);
    cyc();
    imem_bus.imem_done = 1'b0;
    #1;
    check("t1_c3_valid", 32'(instr_valid), 32'd1);
    check("t1_c3_instr", 32'(instr),       32'h4123);
    check("t1_c3_pc",    32'(pc),          32'h0000);
    check("t1_c3_pcinc", 32'(pc_inc),      32'h0002);
    cyc(); #1;
    check("t1_c4_addr",  32'(imem_bus.imem_addr), 32'h0002);
    check("t1_c4_rd",    32'(imem_bus.imem_rd),   32'd1);
    check("t1_c4_valid", 32'(instr_valid),        32'd0);

    // imem_stall for 2 cycles, done on third WAIT cycle; valid at cycle 7
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cyc();
      stall = 1'b1;
      imem_bus.imem_stall = t_stall[i];
      imem_bus.imem_done  = t_done[i];
      imem_bus.imem_data  = 16'h1234;
      #1;
      check($sformatf("t2_rd_%0d", i),    32'(imem_bus.imem_rd), 32'(t_rd[i]));
      check($sformatf("t2_valid_%0d", i), 32'(instr_valid),      32'(t_valid[i]));
      check($sformatf("t2_instr_%0d", i), 32'(instr), t_valid[i] ? 32'h1234 : 32'h0800);
    end
    imem_bus.imem_done = 1'b0;

    // HOLD under stall ignores redirect/next_pc, then redirect on consume
    for (int i = 0; i < 4; i++) begin
      cyc();
      stall = 1'b1; redirect = 1'b1;
      next_pc = i[0] ? 16'h0100 : 16'h0200;
      #1;
      check($sformatf("t3_valid_%0d", i), 32'(instr_valid), 32'd1);
      check($sformatf("t3_pc_%0d", i),    32'(pc),          32'h0000);
      check($sformatf("t3_instr_%0d", i), 32'(instr),       32'h1234);
    end
    consume(1'b1, 16'h0040, 1'b0);
    check("t3_addr", 32'(imem_bus.imem_addr), 32'h0040);
    check("t3_rd",   32'(imem_bus.imem_rd),   32'd1);

    // PC wrap, then misaligned redirect
    fetch_to_hold(16'h5555);
    check("t4_instr", 32'(instr),  32'h5555);
    check("t4_pcinc", 32'(pc_inc), 32'h0042);
    consume(1'b1, 16'hFFFE, 1'b0);
    check("t4_addr_fffe", 32'(imem_bus.imem_addr), 32'hFFFE);
    fetch_to_hold(16'h6666);
    check("t4_pc_fffe",  32'(pc),     32'hFFFE);
    check("t4_inc_wrap", 32'(pc_inc), 32'h0000);
    consume(1'b0, 16'h1111, 1'b0);
    check("t4_addr_wrap", 32'(imem_bus.imem_addr), 32'h0000);
    check("t4_err_wrap",  32'(err),                32'd0);
    fetch_to_hold(16'h7777);
    consume(1'b1, 16'h0031, 1'b0);
    check("t4_odd_rd",   32'(imem_bus.imem_rd),   32'd0);
    check("t4_odd_addr", 32'(imem_bus.imem_addr), 32'h0031);
    rd_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      imem_bus.imem_stall = i[0];
      imem_bus.imem_done  = 1'b1;
      #1;
      rd_seen = rd_seen | imem_bus.imem_rd;
    end
    check("t4_err",     32'(err),         32'd1);
    check("t4_valid",   32'(instr_valid), 32'd0);
    check("t4_rd_seen", 32'(rd_seen),     32'd0);

    // halt on consume freezes everything
    do_reset();
    fetch_to_hold(16'h2222);
    consume(1'b0, 16'h0000, 1'b1);
    rd_seen = 1'b0; valid_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_bus.imem_done = i[0];
      #1;
      rd_seen    = rd_seen | imem_bus.imem_rd;
      valid_seen = valid_seen | instr_valid;
      cyc();
    end
    imem_bus.imem_done = 1'b0;
    #1;
    check("t5_rd_seen",    32'(rd_seen),    32'd0);
    check("t5_valid_seen", 32'(valid_seen), 32'd0);
    check("t5_pc",         32'(pc),         32'h0000);
    check("t5_instr",      32'(instr),      32'h0800);
    check("t5_err",        32'(err),        32'd0);

    // imem_err wins over imem_done in WAIT
    do_reset();
    cyc();
    imem_bus.imem_done = 1'b1; imem_bus.imem_err = 1'b1; imem_bus.imem_data = 16'h9999;
    cyc();
    clear_mem();
    #1;
    check("t5e_err",   32'(err),         32'd1);
    check("t5e_valid", 32'(instr_valid), 32'd0);
    check("t5e_instr", 32'(instr),       32'h0800);
    cyc(); cyc(); #1;
    check("t5e_sticky", 32'(err), 32'd1);

    // reset mid-WAIT with a stale done right after
    do_reset();
    check("t6_err_clr", 32'(err), 32'd0);
    cyc();
    rst = 1'b1;
    #1;
    check("t6_wait_rd", 32'(imem_bus.imem_rd), 32'd0);
    cyc();
    rst = 1'b0;
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'hBAD0;
    #1;
    check("t6_req_rd",    32'(imem_bus.imem_rd),   32'd1);
    check("t6_req_addr",  32'(imem_bus.imem_addr), 32'h0000);
    check("t6_req_valid", 32'(instr_valid),        32'd0);
    cyc();
    imem_bus.imem_done = 1'b0;
    #1;
    check("t6_wait_valid", 32'(instr_valid), 32'd0);
    imem_bus.imem_done = 1'b1; imem_bus.imem_data = 16'h3333;
    cyc();
    imem_bus.imem_done = 1'b0;
    #1;
    check("t6_hold_valid", 32'(instr_valid), 32'd1);
    check("t6_hold_instr", 32'(instr),       32'h3333);
    check("t6_hold_pc",    32'(pc),          32'h0000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
